uart_fifo_bridge: RTL and testbench



---
 rtl/uart_fifo_bridge_if.sv | 23 ++
 rtl/uart_fifo_bridge.sv | 138 +++++++++++++
 tb/tb_uart_fifo_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_bridge_if.sv
// rtl/uart_fifo_bridge_if.sv - CPU register bus and uart register port of the bridge
interface uart_fifo_bridge_if;
  logic        enable_i;
  logic [3:0]  wstrb_i;
  logic [31:0] addr_i;
  logic [31:0] wvalue_i;
  logic [31:0] rvalue_o;
  logic        uart_enable_o;
  logic [3:0]  uart_wstrb_o;
  logic [31:0] uart_addr_o;
  logic [31:0] uart_wvalue_o;
  logic [31:0] uart_rvalue_i;

  modport slave (
    input  enable_i, wstrb_i, addr_i, wvalue_i, uart_rvalue_i,
    output rvalue_o, uart_enable_o, uart_wstrb_o, uart_addr_o, uart_wvalue_o
  );

  modport master (
    output enable_i, wstrb_i, addr_i, wvalue_i, uart_rvalue_i,
    input  rvalue_o, uart_enable_o, uart_wstrb_o, uart_addr_o, uart_wvalue_o
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - TX/RX byte FIFOs between the CPU bus and a polled uart register port
module uart_fifo_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  uart_fifo_bridge_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef enum logic [2:0] {S_IDLE, S_RX_REQ, S_RX_RSP, S_TX_REQ, S_TX_RSP} state_t;

  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  ptr_t   tx_wr, tx_rd, rx_wr, rx_rd;
  cnt_t   tx_count, rx_count;
  logic   tx_ovf, req_en_q;
  state_t state, next_state;

  logic        tx_full, tx_empty, rx_full, rx_nonempty;
  logic [1:0]  addr_sel;
  logic        cpu_wr_b0, cpu_rd, tx_push_req, tx_push, tx_pop, rx_push, rx_pop, ovf_clr;
  logic        u_enable;
  logic [3:0]  u_wstrb;
  logic [31:0] u_addr, u_wvalue, status, rd_next;

  assign tx_full     = (tx_count == cnt_t'(DEPTH));
  assign tx_empty    = (tx_count == '0);
  assign rx_full     = (rx_count == cnt_t'(DEPTH));
  assign rx_nonempty = (rx_count != '0);

  assign addr_sel    = bus.addr_i[3:2];
  assign cpu_wr_b0   = bus.enable_i & bus.wstrb_i[0];
  assign cpu_rd      = bus.enable_i & (bus.wstrb_i == 4'b0000);
  assign tx_push_req = cpu_wr_b0 & (addr_sel == 2'd0);
  // A full FIFO still accepts a push when the sequencer frees a slot in the same cycle
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign rx_pop      = cpu_rd & (addr_sel == 2'd1) & rx_nonempty;
  assign ovf_clr     = cpu_wr_b0 & (addr_sel == 2'd2) & bus.wvalue_i[4];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    u_enable   = 1'b0;
    u_wstrb    = 4'b0000;
    u_addr     = 32'd0;
    u_wvalue   = 32'd0;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    case (state)
      S_IDLE:   next_state = S_RX_REQ;
      S_RX_REQ: begin
        // Enabled read consumes the uart holding register; with no room we only peek
        u_addr     = 32'd4;
        u_enable   = ~rx_full;
        next_state = S_RX_RSP;
      end
      S_RX_RSP: begin
        rx_push    = req_en_q & bus.uart_rvalue_i[8];
        next_state = tx_empty ? S_RX_REQ : S_TX_REQ;
      end
      S_TX_REQ: next_state = S_TX_RSP;
      S_TX_RSP: begin
        if (bus.uart_rvalue_i[10:0] == 11'h7FF && !tx_empty) begin
          u_enable = 1'b1;
          u_wstrb  = 4'b0001;
          u_wvalue = {24'd0, tx_mem[tx_rd]};
          tx_pop   = 1'b1;
        end
        next_state = S_RX_REQ;
      end
      default:  next_state = S_IDLE;
    endcase
  end

  assign bus.uart_enable_o = u_enable;
  assign bus.uart_wstrb_o  = u_wstrb;
  assign bus.uart_addr_o   = u_addr;
  assign bus.uart_wvalue_o = u_wvalue;

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr] <= bus.wvalue_i[7:0];
    if (rx_push) rx_mem[rx_wr] <= bus.uart_rvalue_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      tx_count <= '0;
      rx_count <= '0;
      tx_ovf   <= 1'b0;
      req_en_q <= 1'b0;
    end else begin
      req_en_q <= (state == S_RX_REQ) & ~rx_full;
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
      if (tx_push_req && tx_full && !tx_pop) tx_ovf <= 1'b1;
      else if (ovf_clr)                      tx_ovf <= 1'b0;
    end
  end

  assign status = {8'd0, 8'(rx_count), 8'(tx_count), 3'd0,
                   tx_ovf, rx_full, rx_nonempty, tx_empty, tx_full};

  always_comb begin
    rd_next = 32'd0;
    case (addr_sel)
      2'd1:    rd_next = rx_nonempty ? {23'd0, 1'b1, rx_mem[rx_rd]} : 32'd0;
      2'd2:    rd_next = status;
      default: rd_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bus.rvalue_o <= 32'd0;
    else       bus.rvalue_o <= rd_next;
  end

  logic unused_bits;
  assign unused_bits = ^{bus.addr_i[31:4], bus.addr_i[1:0], bus.wvalue_i[31:8],
                         bus.uart_rvalue_i[31:11]};
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb/tb_uart_fifo_bridge.sv - self-checking bench for uart_fifo_bridge with a polled uart model
module tb_uart_fifo_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_fifo_bridge_if bus();

  uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tx_writes = 0;
  logic       uart_idle = 1'b0;
  logic [7:0] rx_inj_data = 8'h00;
  int         rx_inj_cnt = 0;
  int         rx_taken_cnt = 0;
  logic [7:0] tx_sb[$];
  logic [7:0] rx_sb[$];

  typedef struct {
    logic        en;
    logic [3:0]  ws;
    logic [31:0] addr;
    logic [31:0] wv;
    logic        push;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu(input logic en, input logic [3:0] ws, input logic [31:0] a,
                     input logic [31:0] wv, output logic [31:0] rd);
    @(negedge clk);
    bus.enable_i = en;
    bus.wstrb_i  = ws;
    bus.addr_i   = a;
    bus.wvalue_i = wv;
    @(posedge clk);
    #1;
    rd = bus.rvalue_o;
    bus.enable_i = 1'b0;
    bus.wstrb_i  = 4'b0000;
  endtask

  // uart model: registered read data for the previous cycle's address
  always @(posedge clk) begin
    if (bus.uart_addr_o[2]) begin
      bus.uart_rvalue_i <= {23'd0, rx_inj_cnt != rx_taken_cnt, rx_inj_data};
      if (bus.uart_enable_o && rx_inj_cnt != rx_taken_cnt) rx_taken_cnt <= rx_taken_cnt + 1;
    end else begin
      bus.uart_rvalue_i <= uart_idle ? 32'h0000_07FF : 32'h0;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.uart_enable_o && bus.uart_wstrb_o != 4'b0000) begin
      tx_writes++;
      check("tx_wstrb", {28'd0, bus.uart_wstrb_o}, 32'h1);
      check("tx_addr", bus.uart_addr_o, 32'h0);
      if (tx_sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got write %h expected none", bus.uart_wvalue_o);
      end else begin
        check("tx_data", bus.uart_wvalue_o, {24'd0, tx_sb.pop_front()});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int start;
    bit found;

    vt[0]  = '{1'b1, 4'h0, 32'h8, 32'h0,        1'b0, 32'h0000_0002};
    vt[1]  = '{1'b1, 4'h0, 32'h4, 32'h0,        1'b0, 32'h0};
    vt[2]  = '{1'b1, 4'h0, 32'hC, 32'h0,        1'b0, 32'h0};
    vt[3]  = '{1'b1, 4'h1, 32'h0, 32'hA5,       1'b1, 32'h0};
    vt[4]  = '{1'b1, 4'h0, 32'h8, 32'h0,        1'b0, 32'h0000_0100};
    vt[5]  = '{1'b1, 4'hF, 32'hC, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 4'h2, 32'h0, 32'h11,       1'b0, 32'h0};
    vt[7]  = '{1'b0, 4'h1, 32'h0, 32'h22,       1'b0, 32'h0};
    vt[8]  = '{1'b1, 4'h0, 32'h8, 32'h0,        1'b0, 32'h0000_0100};
    vt[9]  = '{1'b1, 4'h1, 32'h8, 32'h10,       1'b0, 32'h0000_0100};
    vt[10] = '{1'b1, 4'h0, 32'h8, 32'h0,        1'b0, 32'h0000_0100};

    bus.enable_i = 1'b0;
    bus.wstrb_i  = 4'b0;
    bus.addr_i   = 32'h0;
    bus.wvalue_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rvalue", bus.rvalue_o, 32'h0);
    check("reset_uart_enable", {31'd0, bus.uart_enable_o}, 32'h0);
    check("reset_uart_addr", bus.uart_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Register map vectors with the uart reporting busy
    for (int i = 0; i < 11; i++) begin
      cpu(vt[i].en, vt[i].ws, vt[i].addr, vt[i].wv, rd);
      if (vt[i].push) tx_sb.push_back(vt[i].wv[7:0]);
      check($sformatf("vec%0d", i), rd, vt[i].exp);
    end

    // Fill to 16 and overflow once
    for (int i = 0; i < 16; i++) begin
      cpu(1'b1, 4'h1, 32'h0, 32'h10 + 32'(i), rd);
      if (i < 15) tx_sb.push_back(8'(8'h10 + i));
    end
    cpu(1'b1, 4'h0, 32'h8, 32'h0, rd);
    check("status_full_ovf", rd, 32'h0000_1011);
    cpu(1'b1, 4'h1, 32'h8, 32'h10, rd);
    cpu(1'b1, 4'h0, 32'h8, 32'h0, rd);
    check("status_ovf_cleared", rd, 32'h0000_1001);

    // CPU push in the same cycle the sequencer pops from a full FIFO
    uart_idle = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (bus.uart_enable_o && bus.uart_wstrb_o == 4'b0001) found = 1'b1;
    end
    check("coincide_found", {31'd0, found}, 32'h1);
    bus.enable_i = 1'b1;
    bus.wstrb_i  = 4'h1;
    bus.addr_i   = 32'h0;
    bus.wvalue_i = 32'h5A;
    tx_sb.push_back(8'h5A);
    @(posedge clk);
    #1;
    bus.enable_i = 1'b0;
    bus.wstrb_i  = 4'h0;
    uart_idle = 1'b0;
    cpu(1'b1, 4'h0, 32'h8, 32'h0, rd);
    check("status_coincide", rd, 32'h0000_1001);

    uart_idle = 1'b1;
    for (int k = 0; k < 300 && tx_sb.size() != 0; k++) @(posedge clk);
    check("tx_drained", tx_sb.size(), 32'h0);
    repeat (4) @(posedge clk);
    cpu(1'b1, 4'h0, 32'h8, 32'h0, rd);
    check("status_drained", rd, 32'h0000_0002);

    // Idle-to-write latency
    cpu(1'b1, 4'h1, 32'h0, 32'h41, rd);
    tx_sb.push_back(8'h41);
    start = tx_writes;
    for (int k = 0; k < 4 && tx_writes == start; k++) begin
      @(negedge clk);
      #1;
    end
    check("tx_latency_le4", tx_writes - start, 32'h1);
    repeat (8) @(posedge clk);
    check("tx_single_write", tx_writes - start, 32'h1);
    cpu(1'b1, 4'h0, 32'h8, 32'h0, rd);
    check("status_after_41", rd, 32'h0000_0002);

    // RX: one valid byte in the uart holding register
    uart_idle = 1'b0;
    rx_inj_data = 8'h55;
    rx_inj_cnt++;
    rx_sb.push_back(8'h55);
    repeat (12) @(posedge clk);
    check("rx_consumed_once", rx_taken_cnt, rx_inj_cnt);
    cpu(1'b1, 4'h0, 32'h8, 32'h0, rd);
    check("status_rx1", rd, 32'h0001_0006);
    cpu(1'b1, 4'h0, 32'h4, 32'h0, rd);
    check("rxdata_first", rd, {23'd0, 1'b1, rx_sb.pop_front()});
    cpu(1'b1, 4'h0, 32'h4, 32'h0, rd);
    check("rxdata_empty", rd, 32'h0);
    cpu(1'b1, 4'h0, 32'h8, 32'h0, rd);
    check("status_rx_drained", rd, 32'h0000_0002);

    // Reset during the write cycle
    cpu(1'b1, 4'h1, 32'h0, 32'h77, rd);
    tx_sb.push_back(8'h77);
    uart_idle = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #1;
      if (bus.uart_enable_o && bus.uart_wstrb_o == 4'b0001) found = 1'b1;
    end
    check("rst_write_found", {31'd0, found}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_enable_drop", {31'd0, bus.uart_enable_o}, 32'h0);
    tx_sb.delete();
    start = tx_writes;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cpu(1'b1, 4'h0, 32'h8, 32'h0, rd);
    check("status_after_rst", rd, 32'h0000_0002);
    repeat (20) @(posedge clk);
    check("no_stale_write", tx_writes - start, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
